// File: rtl/sdram_arb_pkg.sv
// Shared constants and state encoding for the three-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REQ_UART   = 2'd0;
  localparam logic [1:0] REQ_DATA   = 2'd1;
  localparam logic [1:0] REQ_IFETCH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after (last+1) mod NREQ.
module rr_picker
  import sdram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      winner
);

  always_comb begin
    int unsigned idx;
    logic [1:0]  cand;
    valid  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(last) + k) % NREQ;
      cand = 2'(idx);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among UART loader, data port and ifetch.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = sdram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = sdram_arb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          grant_q, grant_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_valid;
  logic [1:0]          pick_winner;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_picker u_picker (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    sel_we    = we[2];
    sel_addr  = addr[2*ADDR_W +: ADDR_W];
    sel_wdata = wdata[2*DATA_W +: DATA_W];
    case (pick_winner)
      REQ_UART: begin
        sel_we    = we[0];
        sel_addr  = addr[0 +: ADDR_W];
        sel_wdata = wdata[0 +: DATA_W];
      end
      REQ_DATA: begin
        sel_we    = we[1];
        sel_addr  = addr[ADDR_W +: ADDR_W];
        sel_wdata = wdata[DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      last_q      <= REQ_IFETCH;
      grant_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ISSUE;
          grant_d     = pick_winner;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!mem_we_q) rdata_d = mem_rdata;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset clears them without waiting for a clock.
  always_comb begin
    mem_req = (state_q == ST_ISSUE);
    busy    = (state_q != ST_IDLE);
    done    = '0;
    if (state_q == ST_DONE) done = NREQ'(1) << grant_q;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus pushes expected grants, a monitor checks issue and done.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]    id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      done;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;
  logic [1:0]      grant_id;
  logic            busy;

  logic            resp_ack;
  logic            spur_ack;
  logic [DW-1:0]   resp_rdata;
  int              ack_delay;

  exp_t            sb_q[$];
  int              checks;
  int              errors;
  int              done_cnt;

  assign mem_ack   = resp_ack | spur_ack;
  assign mem_rdata = spur_ack ? 32'hBAD0BAD0 : resp_rdata;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.id = id; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s timeout done_cnt=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_issue(input int budget, input string name);
    int n;
    n = 0;
    while (!mem_req && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (!mem_req) begin
      checks++; errors++;
      $display("FAIL %s timeout mem_req=0 required=1", name);
    end
  endtask

  // SDRAM controller model: acks ack_delay cycles after it first sees mem_req.
  initial begin
    resp_ack   = 1'b0;
    resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && rstn) begin
        for (int k = 0; k < ack_delay; k++) begin
          @(posedge clk); #1;
        end
        if (mem_req) begin
          resp_ack   = 1'b1;
          resp_rdata = (mem_addr == 25'h100) ? 32'hDEADBEEF : {16'hC0DE, mem_addr[15:0]};
          @(posedge clk); #1;
          resp_ack   = 1'b0;
        end
      end
    end
  end

  initial begin
    logic       prev_req;
    logic [2:0] prev_done;
    exp_t       e;
    prev_req  = 1'b0;
    prev_done = '0;
    forever begin
      @(negedge clk);
      check("done_onehot0", 64'($onehot0(done)), 64'd1);
      if (mem_req) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue actual=addr %0h required=no request", mem_addr);
        end else begin
          e = sb_q[0];
          check("issue_addr", 64'(mem_addr), 64'(e.addr));
          check("issue_we", 64'(mem_we), 64'(e.we));
          check("issue_grant", 64'(grant_id), 64'(e.id));
          if (e.we) check("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      if (done != '0) begin
        check("done_one_cycle", 64'(prev_done), 64'd0);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=%b required=000", done);
        end else begin
          e = sb_q.pop_front();
          check("done_bit", 64'(done), 64'(3'b001 << e.id));
          check("done_rdata", 64'(rdata), 64'(e.rdata));
          check("done_mem_req", 64'(mem_req), 64'd0);
        end
        done_cnt++;
      end
      prev_req  = mem_req;
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    spur_ack = 1'b0; ack_delay = 2;

    repeat (2) @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single read from the data port
    @(posedge clk); #1;
    addr[1*AW +: AW] = 25'h0000100;
    push(2'd1, 1'b0, 25'h100, '0, 32'hDEADBEEF);
    req = 3'b010;
    wait_dones(1, 20, "single_read");
    @(posedge clk); #1 req = '0;

    // All three requesting from reset: 0,1,2,0,1,2
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    ack_delay = 1;
    addr[0 +: AW] = 25'h10; addr[AW +: AW] = 25'h11; addr[2*AW +: AW] = 25'h12;
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 1'b0, 25'h10, '0, 32'hC0DE0010);
      push(2'd1, 1'b0, 25'h11, '0, 32'hC0DE0011);
      push(2'd2, 1'b0, 25'h12, '0, 32'hC0DE0012);
    end
    req = 3'b111;
    wait_dones(done_cnt + 6, 60, "round_robin");
    @(posedge clk); #1 req = '0;

    // Zero-wait write: rdata must keep the last read value
    @(posedge clk); #1;
    ack_delay = 0;
    we = 3'b001; addr[0 +: AW] = 25'h40; wdata[0 +: DW] = 32'h12345678;
    push(2'd0, 1'b1, 25'h40, 32'h12345678, 32'hC0DE0012);
    req = 3'b001;
    @(posedge clk);
    @(negedge clk);
    check("zw_issue_mem_req", 64'(mem_req), 64'd1);
    check("zw_issue_done", 64'(done), 64'd0);
    @(negedge clk);
    check("zw_done_latency", 64'(done), 64'b001);
    @(posedge clk); #1 req = '0; we = '0;

    // Requester 2 withdraws during ISSUE; requester 0 still pending
    @(posedge clk); #1;
    ack_delay = 2;
    addr[0 +: AW] = 25'h20; addr[2*AW +: AW] = 25'h22;
    push(2'd2, 1'b0, 25'h22, '0, 32'hC0DE0022);
    push(2'd0, 1'b0, 25'h20, '0, 32'hC0DE0020);
    req = 3'b101;
    wait_issue(10, "withdraw_issue");
    @(posedge clk); #1 req = 3'b001;
    wait_dones(done_cnt + 2, 30, "withdraw");
    @(posedge clk); #1 req = '0;

    // Reset during ISSUE aborts with no done
    @(posedge clk); #1;
    ack_delay = 3;
    addr[AW +: AW] = 25'h30;
    push(2'd1, 1'b0, 25'h30, '0, 32'h0);
    req = 3'b010;
    wait_issue(10, "abort_issue");
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    req = '0;
    void'(sb_q.pop_front());
    @(posedge clk); #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ack_delay = 1;
    addr[2*AW +: AW] = 25'h44;
    push(2'd2, 1'b0, 25'h44, '0, 32'hC0DE0044);
    req = 3'b100;
    wait_dones(done_cnt + 1, 20, "post_reset_2");
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
    addr[0 +: AW] = 25'h50; addr[AW +: AW] = 25'h51;
    push(2'd0, 1'b0, 25'h50, '0, 32'hC0DE0050);
    push(2'd1, 1'b0, 25'h51, '0, 32'hC0DE0051);
    req = 3'b011;
    wait_dones(done_cnt + 2, 30, "post_reset_011");
    @(posedge clk); #1 req = '0;

    // Spurious ack while idle
    @(posedge clk); #1 spur_ack = 1'b1;
    @(posedge clk); #1 spur_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_busy", 64'(busy), 64'd0);
      check("spur_done", 64'(done), 64'd0);
      check("spur_rdata", 64'(rdata), 64'hC0DE0051);
    end
    check("spur_grant", 64'(grant_id), 64'd1);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25: word address width of the SDRAM controller port.
REQ-002 Parameter DATA_W, default 32: data width of every port.
REQ-003 clk  input  1  single core clock; all logic is on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-requester request; bit 0 = UART loader, bit 1 = data port, bit 2 = instruction fetch.
REQ-006 we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-007 addr  input  3*ADDR_W  per-requester address; slice i is requester i.
REQ-008 wdata  input  3*DATA_W  per-requester write data; slice i is requester i.
REQ-009 done  output  3  one-hot completion pulse to the granted requester.
REQ-010 rdata  output  DATA_W  read data, shared by all requesters.
REQ-011 mem_req  output  1  request to the SDRAM controller.
REQ-012 mem_we  output  1  write enable to the SDRAM controller.
REQ-013 mem_addr  output  ADDR_W  address to the SDRAM controller.
REQ-014 mem_wdata  output  DATA_W  write data to the SDRAM controller.
REQ-015 mem_rdata  input  DATA_W  read data from the SDRAM controller.
REQ-016 mem_ack  input  1  controller completion; one-cycle pulse.
REQ-017 grant_id  output  2  index of the current or last granted requester, for the 7-segment debug display.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-020 IDLE: when req is nonzero, the arbiter SHALL pick a winner by round-robin, searching from (last+1) mod 3 upward with wrap-around.
- Same edge: latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata; set grant_id to the winner; move to ISSUE.
REQ-021 ISSUE: mem_req SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL stay stable until mem_ack is sampled high.
- On mem_ack: for a read, capture mem_rdata into rdata; move to DONE.
- mem_ack may arrive in the first ISSUE cycle.
REQ-022 DONE: done[grant_id] SHALL be 1 for exactly one cycle, mem_req SHALL be 0, last SHALL take grant_id, and the FSM SHALL return to IDLE.
REQ-023 rdata SHALL hold its value from capture until the next read capture; writes SHALL NOT change rdata.
REQ-024 Latency: req sampled at edge t gives mem_req high in cycle t+1; mem_ack at edge a gives done high in cycle a+1. Minimum 3 cycles per transaction.
REQ-025 mem_ack seen in IDLE or DONE SHALL be ignored.
REQ-026 Once latched, a transaction SHALL complete even if the requester drops req; done still pulses.
REQ-027 Requesters hold req until done. A req still high in the cycle after done SHALL be treated as a new request.
REQ-028 Fairness: with all three requesters continuously requesting, each SHALL be granted once in every 3 consecutive grants.
REQ-029 done SHALL be zero in every cycle except the DONE cycle, and SHALL never have more than one bit set.

Reset
REQ-030 When rstn is low: state=IDLE, last=2 (so requester 0 wins first), done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, grant_id=0, busy=0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately with no done pulse. The SDRAM controller is reset by the same rstn.

Structure
REQ-032 A shared package sdram_arb_pkg SHALL hold NREQ=3, ADDR_W, DATA_W, the requester index constants and the state encoding.
REQ-033 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs req and last; outputs valid and 2-bit winner). All state SHALL stay in sdram_arbiter.

Verification
REQ-034 Single read: req=3'b010, we=0, addr=0x0000100; controller acks 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x0000100, done=3'b010 for one cycle, rdata=0xDEADBEEF.
REQ-035 Simultaneous: after reset, req=3'b111 held -> grant order 0,1,2,0,1,2 and done pulses in that order.
REQ-036 Zero-wait ack: mem_ack high in the first ISSUE cycle of a write with wdata=0x12345678 -> done exactly 2 cycles after req sampled; rdata unchanged.
REQ-037 Withdrawn req: req[2] dropped during ISSUE -> transaction completes, done[2] pulses, next grant goes to another pending requester.
REQ-038 Reset mid-ISSUE: rstn low for 1 cycle -> mem_req=0, done=0, busy=0 immediately; the next grant with req=3'b100 goes to requester 2 and a later req=3'b011 goes to requester 0.
REQ-039 Spurious ack: mem_ack pulsed in IDLE with req=0 -> no state change, no done, rdata unchanged.
